tow_game_ctrl: RTL and testbench
================================

// Module: tow_game_ctrl
// PURPOSE
//  Round/match controller for the tug-of-war light chain (centre light plus edge lights).
//  Conditions raw player keys into single-cycle press pulses and gates them to the chain.
//  Detects a round win from the chain's outermost lights, keeps per-player scores and restarts the chain.
//  Freezes the game when one player reaches the match limit.
// PARAMETERS
//  SCORE_W     3    width of each score counter
//  MAX_SCORE   7    score that ends the match (1..2**SCORE_W-1)
//  HOLD_CYC    4    cycles spent in the WIN_x state before the chain restarts (>=1)
// PORTS
//  Clock       in   1        single clock domain
//  Reset       in   1        synchronous, active-low; sampled on posedge Clock
//  keyL        in   1        raw left key, active-high, asynchronous to Clock
//  keyR        in   1        raw right key, active-high, asynchronous to Clock
//  edgeL       in   1        leftmost chain light is lit
//  edgeR       in   1        rightmost chain light is lit
//  pressL      out  1        left press pulse to the chain (L input), 1 cycle
//  pressR      out  1        right press pulse to the chain (R input), 1 cycle
//  chainReset  out  1        active-high reset to the light chain; re-centres the light
//  scoreL      out  SCORE_W  left player rounds won
//  scoreR      out  SCORE_W  right player rounds won
//  winner      out  2        00 none, 01 left round, 10 right round, 11 match over
// BEHAVIOUR
//  Reset low: state=RESET_CH, scores=0, pressL/R=0, chainReset=1, winner=00, sync/edge flops=0.
//  Key conditioning (per key): 2-flop synchroniser, then rising-edge detection into a registered internal pulse kp.
//   kp is high for exactly 1 cycle per 0->1 transition.
//   Latency: the first edge sampling the key high is edge k; kp is high in the cycle after edge k+2.
//   Holding a key does not repeat the pulse.
//  FSM (all outputs are registered):
//   RESET_CH: chainReset=1 for exactly 1 cycle -> PLAY.
//   PLAY: winner=00.
//    kpL&kpR in the same cycle: both are discarded, nothing is forwarded, no win.
//    kpL alone with edgeL=1: left wins the round. The press is not forwarded. Next cycle scoreL+1 and -> WIN_L.
//    kpR alone with edgeR=1: mirror of the left case (scoreR+1, -> WIN_R).
//    Otherwise kpL/kpR is forwarded as pressL/pressR in the next cycle.
//   WIN_L/WIN_R: winner=01/10, presses masked, hold counter runs HOLD_CYC cycles.
//    On expiry: if the winning score == MAX_SCORE -> OVER, else -> RESET_CH.
//   OVER: winner=11, presses masked, chainReset=0, scores frozen. Only Reset low exits.
//  Scores saturate; they cannot exceed MAX_SCORE because OVER is entered first.
//  Reset low mid-round or mid-hold: immediate return to the reset values; the pending win is discarded.
//  edgeL and edgeR high together (illegal chain state): left is checked first; no error flag.
// STRUCTURE
//  Package tow_pkg: state enum {RESET_CH, PLAY, WIN_L, WIN_R, OVER}; winner codes W_NONE/W_LEFT/W_RIGHT/W_OVER.
//  Sub-module key_press (synchroniser + edge pulse), instantiated once per key.
//  The top level holds the FSM, the hold counter and the score counters.
// TESTING
//  1 Reset low 2 cycles then high -> chainReset=1 for exactly 1 cycle, then PLAY; scores 0/0, winner=00.
//  2 keyL high for 10 cycles, edgeL=0 -> exactly one pressL pulse, 3 edges after the key is first sampled; no score change.
//  3 keyL and keyR rise on the same cycle -> no pressL/pressR, state stays PLAY.
//  4 edgeL=1 then keyL press -> pressL not pulsed, scoreL 0->1, winner=01 for HOLD_CYC cycles, then a 1-cycle chainReset.
//  5 seven right-round wins (MAX_SCORE=7) -> scoreR=7, winner=11, later presses ignored, no chainReset until Reset.
//  6 Reset low during WIN_R hold -> scores=0, winner=00, chainReset=1 on the cycle after Reset is released.

Source files
------------

// File: rtl/tow_game_ctrl_pkg.sv
// tow_pkg: states, winner codes and the winner-code mapping for the tug-of-war controller.
package tow_pkg;
  typedef enum logic [2:0] {RESET_CH, PLAY, WIN_L, WIN_R, OVER} state_t;
  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_LEFT  = 2'b01;
  localparam logic [1:0] W_RIGHT = 2'b10;
  localparam logic [1:0] W_OVER  = 2'b11;
  function automatic logic [1:0] win_code(state_t s);
    return s == WIN_L ? W_LEFT : s == WIN_R ? W_RIGHT : s == OVER ? W_OVER : W_NONE;
  endfunction
endpackage

// File: rtl/tow_game_ctrl_if.sv
// tow_game_ctrl_if: player keys, chain edge lights and the controller's outputs.
interface tow_game_ctrl_if #(parameter int SCORE_W = 3);
  logic keyL, keyR, edgeL, edgeR;
  logic pressL, pressR, chainReset;
  logic [SCORE_W-1:0] scoreL, scoreR;
  logic [1:0] winner;
  modport master(input keyL, keyR, edgeL, edgeR,
                 output pressL, pressR, chainReset, scoreL, scoreR, winner);
  modport slave(output keyL, keyR, edgeL, edgeR,
                input pressL, pressR, chainReset, scoreL, scoreR, winner);
endinterface

// File: rtl/tow_game_ctrl_key_press.sv
// key_press: two-flop synchroniser followed by a registered single-cycle rising-edge pulse.
module key_press (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic kp
);
  logic [2:0] sh;
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sh <= '0;
      kp <= 1'b0;
    end else begin
      sh <= {sh[1:0], key};
      kp <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/tow_game_ctrl.sv
// tow_game_ctrl: round/match FSM, hold timer and score counters for the tug-of-war chain.
module tow_game_ctrl import tow_pkg::*; #(
  parameter int SCORE_W   = 3,
  parameter int MAX_SCORE = 7,
  parameter int HOLD_CYC  = 4
) (
  input logic Clock,
  input logic Reset,
  tow_game_ctrl_if.master bus
);
  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [SCORE_W-1:0] MAX = SCORE_W'(MAX_SCORE);
  state_t state, state_n;
  logic [SCORE_W-1:0] scoreL, scoreR, scoreL_n, scoreR_n;
  logic [CW-1:0] cnt, cnt_n;
  logic kpL, kpR, pressL, pressR, pressL_n, pressR_n, chainReset, hold_done;
  logic [1:0] winner;
  key_press u_key_l (.Clock(Clock), .Reset(Reset), .key(bus.keyL), .kp(kpL));
  key_press u_key_r (.Clock(Clock), .Reset(Reset), .key(bus.keyR), .kp(kpR));
  assign hold_done = cnt == CW'(HOLD_CYC - 1);
  always_comb begin
    state_n  = state;
    scoreL_n = scoreL;
    scoreR_n = scoreR;
    cnt_n    = '0;
    pressL_n = 1'b0;
    pressR_n = 1'b0;
    case (state)
      RESET_CH: state_n = PLAY;
      PLAY: begin
        pressL_n = kpL & ~kpR & ~bus.edgeL;
        pressR_n = kpR & ~kpL & ~bus.edgeR;
        if (kpL & ~kpR & bus.edgeL) begin
          state_n  = WIN_L;
          scoreL_n = scoreL + SCORE_W'(scoreL != MAX);
        end else if (kpR & ~kpL & bus.edgeR) begin
          state_n  = WIN_R;
          scoreR_n = scoreR + SCORE_W'(scoreR != MAX);
        end
      end
      WIN_L: begin
        cnt_n   = hold_done ? '0 : cnt + 1'b1;
        state_n = !hold_done ? WIN_L : scoreL == MAX ? OVER : RESET_CH;
      end
      WIN_R: begin
        cnt_n   = hold_done ? '0 : cnt + 1'b1;
        state_n = !hold_done ? WIN_R : scoreR == MAX ? OVER : RESET_CH;
      end
      default: state_n = OVER;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= RESET_CH;
      scoreL     <= '0;
      scoreR     <= '0;
      cnt        <= '0;
      pressL     <= 1'b0;
      pressR     <= 1'b0;
      chainReset <= 1'b1;
      winner     <= W_NONE;
    end else begin
      state      <= state_n;
      scoreL     <= scoreL_n;
      scoreR     <= scoreR_n;
      cnt        <= cnt_n;
      pressL     <= pressL_n;
      pressR     <= pressR_n;
      chainReset <= state_n == RESET_CH;
      winner     <= win_code(state_n);
    end
  end
  assign bus.pressL     = pressL;
  assign bus.pressR     = pressR;
  assign bus.chainReset = chainReset;
  assign bus.scoreL     = scoreL;
  assign bus.scoreR     = scoreR;
  assign bus.winner     = winner;
endmodule

// File: tb/tb_tow_game_ctrl.sv
// tb_tow_game_ctrl: directed test of key conditioning, round wins, match end and reset behaviour.
module tb_tow_game_ctrl;
  import tow_pkg::*;
  logic Clock = 1'b0;
  logic Reset;
  int vecs = 0;
  int errs = 0;
  int n_pl, n_pr, n_cr, n_win, first;
  tow_game_ctrl_if #(.SCORE_W(3)) bus();
  tow_game_ctrl #(.SCORE_W(3), .MAX_SCORE(7), .HOLD_CYC(4)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic win_right(input int r);
    bus.edgeR = 1'b1;
    bus.keyR  = 1'b1;
    tick(4);
    chk($sformatf("r%0d_winner", r), 32'(bus.winner), 32'(W_RIGHT));
    chk($sformatf("r%0d_scoreR", r), 32'(bus.scoreR), 32'(r));
    bus.keyR = 1'b0;
    tick(5);
  endtask

  initial begin
    Reset = 1'b0;
    bus.keyL = 1'b0; bus.keyR = 1'b0; bus.edgeL = 1'b0; bus.edgeR = 1'b0;
    tick(2);
    chk("rst_chainReset", 32'(bus.chainReset), 32'd1);
    chk("rst_winner", 32'(bus.winner), 32'd0);
    chk("rst_scores", {bus.scoreL, bus.scoreR}, 32'd0);
    chk("rst_press", {bus.pressL, bus.pressR}, 32'd0);
    Reset = 1'b1;
    tick();
    chk("play_chainReset", 32'(bus.chainReset), 32'd0);
    chk("play_state", 32'(dut.state), 32'(PLAY));

    bus.keyL = 1'b1;
    n_pl = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pressL) begin n_pl++; if (first < 0) first = i; end
    end
    bus.keyL = 1'b0;
    chk("hold_pressL_count", 32'(n_pl), 32'd1);
    chk("hold_pressL_latency", 32'(first), 32'd3);
    chk("hold_scoreL", 32'(bus.scoreL), 32'd0);
    tick(3);

    bus.keyL = 1'b1; bus.keyR = 1'b1;
    n_pl = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_pl += int'(bus.pressL) + int'(bus.pressR);
    end
    chk("both_press_count", 32'(n_pl), 32'd0);
    chk("both_state", 32'(dut.state), 32'(PLAY));
    bus.keyL = 1'b0; bus.keyR = 1'b0;
    tick(3);

    bus.edgeL = 1'b1; bus.keyL = 1'b1;
    n_pl = 0; n_win = 0; n_cr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_pl  += int'(bus.pressL);
      n_win += int'(bus.winner == W_LEFT);
      n_cr  += int'(bus.chainReset);
      if (i == 3) chk("winL_first", 32'(bus.winner), 32'(W_LEFT));
    end
    chk("winL_pressL", 32'(n_pl), 32'd0);
    chk("winL_hold_cycles", 32'(n_win), 32'd4);
    chk("winL_chainReset_cycles", 32'(n_cr), 32'd1);
    chk("winL_scoreL", 32'(bus.scoreL), 32'd1);
    tick();
    chk("winL_back_play", 32'(dut.state), 32'(PLAY));
    bus.keyL = 1'b0; bus.edgeL = 1'b0;
    tick(3);

    for (int r = 1; r <= 7; r++) win_right(r);
    chk("over_winner", 32'(bus.winner), 32'(W_OVER));
    chk("over_scoreR", 32'(bus.scoreR), 32'd7);
    chk("over_chainReset", 32'(bus.chainReset), 32'd0);
    bus.keyL = 1'b1;
    n_pl = 0; n_cr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_pl += int'(bus.pressL) + int'(bus.pressR);
      n_cr += int'(bus.chainReset);
    end
    chk("over_press_masked", 32'(n_pl), 32'd0);
    chk("over_no_chainReset", 32'(n_cr), 32'd0);
    chk("over_frozen", {bus.winner, bus.scoreL, bus.scoreR}, {2'b11, 3'd1, 3'd7});
    bus.keyL = 1'b0; bus.edgeR = 1'b0;
    tick(3);

    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    chk("rerst_scores", {bus.scoreL, bus.scoreR}, 32'd0);
    chk("rerst_winner", 32'(bus.winner), 32'd0);
    bus.edgeR = 1'b1; bus.keyR = 1'b1;
    tick(4);
    chk("mid_winner", 32'(bus.winner), 32'(W_RIGHT));
    tick();
    Reset = 1'b0;
    tick();
    chk("mid_rst_scoreR", 32'(bus.scoreR), 32'd0);
    chk("mid_rst_winner", 32'(bus.winner), 32'd0);
    chk("mid_rst_chainReset", 32'(bus.chainReset), 32'd1);
    Reset = 1'b1; bus.keyR = 1'b0;
    #1;
    chk("release_chainReset", 32'(bus.chainReset), 32'd1);
    tick();
    chk("release_play", {bus.chainReset, 1'b0, dut.state}, {1'b0, 1'b0, PLAY});
    n_win = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_win += int'(bus.winner != W_NONE) + int'(bus.scoreR != 0);
    end
    chk("pending_win_discarded", 32'(n_win), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
